// File: rtl/array_shift_down.sv
// array_shift_down
//   Heap-array element remover. Holds NArrays arrays of NArea elements and a
//   per-array size table. A command removes element `index` of array `array`,
//   returns it on `value`, moves every later element down one slot (one per
//   clock) and decrements the size. A write/read port loads and inspects the
//   heap.
// Ports
//   clock, reset          : single clock, synchronous active-low reset
//   start, array, index   : command request (sampled in IDLE only)
//   busy, done, error     : status; done is a one-cycle pulse, error valid with done
//   value                 : removed element, valid with done when error=0
//   wr_en/array/index/data: heap write port (IDLE only)
//   rd_array, rd_index    : combinational read address
//   rd_data, rd_size      : heap element and array size at the read address
module array_shift_down #(
    parameter int MemoryElementWidth = 12,
    parameter int NArea              = 4,
    parameter int NArrays            = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic [MemoryElementWidth-1:0] array,
    input  logic [MemoryElementWidth-1:0] index,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    output logic [MemoryElementWidth-1:0] value,
    input  logic                          wr_en,
    input  logic [MemoryElementWidth-1:0] wr_array,
    input  logic [MemoryElementWidth-1:0] wr_index,
    input  logic [MemoryElementWidth-1:0] wr_data,
    input  logic [MemoryElementWidth-1:0] rd_array,
    input  logic [MemoryElementWidth-1:0] rd_index,
    output logic [MemoryElementWidth-1:0] rd_data,
    output logic [MemoryElementWidth-1:0] rd_size
);
    localparam int MEW   = MemoryElementWidth;
    localparam int DEPTH = NArrays * NArea;
    localparam int AW    = (NArrays > 1) ? $clog2(NArrays) : 1;
    localparam int HW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [MEW-1:0] NAREA_W   = MEW'(NArea);
    localparam logic [MEW-1:0] NARRAYS_W = MEW'(NArrays);
    localparam logic [MEW-1:0] ONE_W     = MEW'(1);

    typedef enum logic [1:0] {IDLE, CHECK, SHIFT, DONE} state_t;

    state_t          r_state, w_next;
    logic [MEW-1:0]  r_heap [DEPTH];
    logic [MEW-1:0]  r_size [NArrays];
    logic [MEW-1:0]  r_a, r_pos, r_value;
    logic            r_error;

    // Command-side views; the array number is range-checked before any use
    // of it as a table index.
    logic            w_a_ok;
    logic [MEW-1:0]  w_size_a, w_pos1;
    logic [HW-1:0]   w_addr, w_addr_nx;

    assign w_a_ok    = (r_a < NARRAYS_W);
    assign w_size_a  = w_a_ok ? r_size[r_a[AW-1:0]] : '0;
    assign w_pos1    = r_pos + ONE_W;
    assign w_addr    = HW'(r_a * NAREA_W + r_pos);
    assign w_addr_nx = HW'(r_a * NAREA_W + w_pos1);

    // Write port view
    logic            w_wr_ok;
    logic [HW-1:0]   w_wr_addr;
    logic [MEW-1:0]  w_wr_sz;

    assign w_wr_ok   = wr_en && (wr_array < NARRAYS_W) && (wr_index < NAREA_W);
    assign w_wr_addr = HW'(wr_array * NAREA_W + wr_index);
    assign w_wr_sz   = wr_index + ONE_W;

    // Read port: out-of-range addresses read as zero
    logic            w_rd_a_ok, w_rd_ok;
    logic [HW-1:0]   w_rd_addr;

    assign w_rd_a_ok = (rd_array < NARRAYS_W);
    assign w_rd_ok   = w_rd_a_ok && (rd_index < NAREA_W);
    assign w_rd_addr = HW'(rd_array * NAREA_W + rd_index);
    assign rd_data   = w_rd_ok   ? r_heap[w_rd_addr]        : '0;
    assign rd_size   = w_rd_a_ok ? r_size[rd_array[AW-1:0]] : '0;

    // State register
    always_ff @(posedge clock) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (start) w_next = CHECK;
            CHECK: w_next = (!w_a_ok || r_pos >= w_size_a) ? DONE : SHIFT;
            SHIFT: if (w_pos1 >= w_size_a) w_next = DONE;
            DONE:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy = (r_state != IDLE);
        done = (r_state == DONE);
    end
    assign error = r_error;
    assign value = r_value;

    // Datapath
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++)   r_heap[i] <= '0;
            for (int i = 0; i < NArrays; i++) r_size[i] <= '0;
            r_a     <= '0;
            r_pos   <= '0;
            r_value <= '0;
            r_error <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // The write lands on the same edge that latches the
                    // command, so CHECK already sees it.
                    if (w_wr_ok) begin
                        r_heap[w_wr_addr] <= wr_data;
                        if (w_wr_sz > r_size[wr_array[AW-1:0]])
                            r_size[wr_array[AW-1:0]] <= w_wr_sz;
                    end
                    if (start) begin
                        r_a   <= array;
                        r_pos <= index;
                    end
                end
                CHECK: begin
                    if (!w_a_ok || r_pos >= w_size_a) begin
                        r_error <= 1'b1;
                    end else begin
                        r_error <= 1'b0;
                        r_value <= r_heap[w_addr];
                    end
                end
                SHIFT: begin
                    // pos+1 < size <= NArea keeps both addresses in range.
                    // The vacated top slot keeps its stale value.
                    if (w_pos1 < w_size_a) begin
                        r_heap[w_addr] <= r_heap[w_addr_nx];
                        r_pos          <= w_pos1;
                    end else begin
                        r_size[r_a[AW-1:0]] <= w_size_a - ONE_W;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_array_shift_down.sv
module tb_array_shift_down;
    localparam int W = 12;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] array = '0, index = '0;
    logic         busy, done, error;
    logic [W-1:0] value;
    logic         wr_en = 1'b0;
    logic [W-1:0] wr_array = '0, wr_index = '0, wr_data = '0;
    logic [W-1:0] rd_array = '0, rd_index = '0;
    logic [W-1:0] rd_data, rd_size;

    array_shift_down #(.MemoryElementWidth(W), .NArea(4), .NArrays(4)) dut (
        .clock(clock), .reset(reset), .start(start), .array(array), .index(index),
        .busy(busy), .done(done), .error(error), .value(value),
        .wr_en(wr_en), .wr_array(wr_array), .wr_index(wr_index), .wr_data(wr_data),
        .rd_array(rd_array), .rd_index(rd_index), .rd_data(rd_data), .rd_size(rd_size)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic         err;
        logic [W-1:0] val;
        int           cyc;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clock) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clock) begin
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("done_error", int'(error), int'(e.err));
                chk("done_value", int'(value), int'(e.val));
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic wr(input int a, input int i, input int d);
        @(negedge clock);
        wr_en = 1'b1; wr_array = W'(a); wr_index = W'(i); wr_data = W'(d);
        @(negedge clock);
        wr_en = 1'b0;
    endtask

    // lat = edges after the sampling edge until done is visible
    task automatic issue(input int a, input int i, input bit push,
                         input bit e_err, input int e_val, input int lat);
        exp_t e;
        @(negedge clock);
        start = 1'b1; array = W'(a); index = W'(i);
        if (push) begin
            e.err = e_err; e.val = W'(e_val); e.cyc = cyc + 1 + lat;
            q.push_back(e);
        end
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy !== 1'b0 || q.size() != 0) && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (n >= 40) begin
            checks++;
            errors++;
            $display("FAIL timeout: got busy=%0d pending=%0d expected idle", busy, q.size());
            q.delete();
        end
    endtask

    task automatic rd(input string name, input int a, input int i, input int exp);
        rd_array = W'(a); rd_index = W'(i);
        #1;
        chk(name, int'(rd_data), exp);
    endtask

    task automatic rs(input string name, input int a, input int exp);
        rd_array = W'(a);
        #1;
        chk(name, int'(rd_size), exp);
    endtask

    task automatic load1();
        wr(1, 0, 99); wr(1, 1, 0); wr(1, 2, 1); wr(1, 3, 2);
    endtask

    initial begin
        // Reset
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_error", int'(error), 0);
        chk("rst_value", int'(value), 0);
        for (int a = 0; a < 4; a++) rs("rst_size", a, 0);
        rd("rst_heap", 2, 3, 0);

        // Remove first element of a full array
        load1();
        rs("load_size", 1, 4);
        issue(1, 0, 1, 0, 99, 5);
        wait_idle();
        rd("rm0_e0", 1, 0, 0); rd("rm0_e1", 1, 1, 1); rd("rm0_e2", 1, 2, 2);
        rs("rm0_size", 1, 3);

        // Remove last element
        load1();
        issue(1, 3, 1, 0, 2, 2);
        wait_idle();
        rd("rm3_e0", 1, 0, 99); rd("rm3_e1", 1, 1, 0); rd("rm3_e2", 1, 2, 1);
        rs("rm3_size", 1, 3);

        // Rejections: index == size, array out of range
        wr(1, 3, 2);
        rs("rej_pre_size", 1, 4);
        issue(1, 4, 1, 1, 2, 1);
        wait_idle();
        issue(5, 0, 1, 1, 2, 1);
        wait_idle();
        rs("rej_size", 1, 4);
        rd("rej_e0", 1, 0, 99); rd("rej_e3", 1, 3, 2);

        // Single-element array, then empty
        wr(2, 0, 7);
        issue(2, 0, 1, 0, 7, 2);
        wait_idle();
        rs("one_size", 2, 0);
        issue(2, 0, 1, 1, 7, 1);
        wait_idle();

        // start/wr_en during SHIFT are ignored
        issue(1, 0, 1, 0, 99, 5);
        @(negedge clock);
        start = 1'b1; array = 3; index = 0;
        wr_en = 1'b1; wr_array = 1; wr_index = 3; wr_data = 55;
        @(negedge clock);
        start = 1'b0; wr_en = 1'b0;
        wait_idle();
        rd("ign_e0", 1, 0, 0); rd("ign_e1", 1, 1, 1); rd("ign_e2", 1, 2, 2);
        rd("ign_e3", 1, 3, 2);
        rs("ign_size1", 1, 3);
        rs("ign_size3", 3, 0);

        // Reset in the middle of SHIFT
        wr(0, 0, 1); wr(0, 1, 2); wr(0, 2, 3); wr(0, 3, 4);
        issue(0, 0, 0, 0, 0, 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        for (int a = 0; a < 4; a++) rs("mid_rst_size", a, 0);
        repeat (6) @(negedge clock);
        issue(0, 0, 1, 1, 0, 1);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
